usart_receiver: RTL and testbench
=================================

USART_RECEIVER -- requirements
Module: usart_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of i_rxd synchronizer flops (min 2).
REQ-002 SHALL have port i_clk  input  1  system clock; all flops on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_rxen  input  1  receiver enable.
REQ-005 SHALL have port i_sample_tick  input  1  one-i_clk-wide sample strobe from the clock generator stage (oversample tick async, bit tick sync).
REQ-006 SHALL have port i_umsel  input  1  0 async, 1 sync.
REQ-007 SHALL have port i_u2x  input  1  async double speed: 8 samples/bit instead of 16.
REQ-008 SHALL have port i_ucsz  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-009 SHALL have port i_upm  input  2  parity: 00/01 none, 10 even, 11 odd.
REQ-010 SHALL have port i_rxd  input  1  serial line, idle high, asynchronous.
REQ-011 SHALL have port i_udr_read  input  1  one-cycle pop strobe for the receive buffer.
REQ-012 SHALL have port o_udr  output  8  head data, LSB-first assembled, unused upper bits 0.
REQ-013 SHALL have port o_rxc  output  1  receive complete: buffer non-empty.
REQ-014 SHALL have ports o_fe, o_upe  output  1 each  frame/parity error of head entry.
REQ-015 SHALL have port o_dor  output  1  sticky data overrun.
REQ-016 SHALL have port o_busy  output  1  FSM not IDLE.

Function
REQ-017 SHALL synchronize i_rxd through SYNC_STAGES flops; all decisions use synchronized value.
REQ-018 FSM states IDLE, START, DATA, PARITY, STOP; FSM advances only on cycles with i_sample_tick=1.
REQ-019 Async: N=16 (i_u2x=0) or 8; sample counter 0..N-1, reset to 0 on each bit entry; bit value = majority of samples 7,8,9 (N=16) or 3,4,5 (N=8), decided at count 9 or 5.
REQ-020 Async IDLE->START on tick with synchronized rxd=0 (that tick is count 0); START mid-bit majority=1 -> IDLE (false start, nothing stored).
REQ-021 Sync: each tick is one bit, value sampled directly at the tick; IDLE->DATA when sampled 0.
REQ-022 DATA collects 5..8 bits per i_ucsz, LSB first; then PARITY if i_upm[1]=1, else STOP.
REQ-023 Parity error SHALL be set when received parity != XOR(data) (even) or != ~XOR(data) (odd).
REQ-024 STOP: only first stop bit checked; at its decision point entry {data,fe=~bit,upe} pushed, FSM -> IDLE same cycle (allows start detection from next tick).
REQ-025 Receive buffer SHALL be 2 entries FIFO; o_udr/o_fe/o_upe show head, valid only while o_rxc=1, else 0.
REQ-026 i_udr_read with o_rxc=1 pops head next cycle; read when empty ignored.
REQ-027 Push with buffer full and no simultaneous pop: new entry discarded, o_dor set.
REQ-028 Push and pop same cycle when full: pop then push, no overrun.
REQ-029 o_dor SHALL clear on the cycle after the next accepted pop.
REQ-030 i_ucsz/i_upm/i_u2x changes mid-frame: behaviour undefined; sampled continuously, not latched.
REQ-031 i_rxen=0: FSM -> IDLE, buffer flushed, o_dor cleared next cycle; i_rxen=1 again starts fresh.

Reset
REQ-032 On i_rst=1, immediately: state IDLE, counters 0, synchronizers 1, buffer empty, o_udr=0, o_rxc=0, o_fe=0, o_upe=0, o_dor=0, o_busy=0.
REQ-033 Reset mid-frame SHALL discard the partial frame; no entry pushed.

Structure
REQ-034 Shared package usart_pkg SHALL hold FSM state enum, UCSZ/UPM encodings, sample counts 16/8 and majority indices.
REQ-035 Buffer SHALL be sub-module usart_rx_fifo (2 entries, 10-bit payload, push/pop/full/empty).

Verification
REQ-036 Async N=16, 8N1, rx 0xA5 -> o_rxc=1, o_udr=0xA5, o_fe=0, o_upe=0.
REQ-037 u2x=1, 7E1, rx 0x35 with wrong parity -> o_udr=0x35, o_upe=1.
REQ-038 Stop bit driven 0 on 0x0F, 8N1 -> o_fe=1, o_udr=0x0F; next frame 0x10 received normally.
REQ-039 Three frames 0x01,0x02,0x03 without reads -> o_dor=1, reads return 0x01,0x02, o_dor clears after first read.
REQ-040 Low glitch of 4 samples on idle line -> no push, o_busy returns 0; i_rst asserted mid-frame -> all outputs 0, no entry.

Source files
------------

// File: rtl/usart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usart_pkg
// Description : Shared types and constants for the USART receive path:
//               FSM state encoding, frame-format encodings, oversampling
//               counts and majority-vote sample positions.
// Revision    : 1.0 - initial release
// ============================================================================
package usart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Character size encodings
  localparam logic [1:0] UCSZ_5 = 2'b00;
  localparam logic [1:0] UCSZ_6 = 2'b01;
  localparam logic [1:0] UCSZ_7 = 2'b10;
  localparam logic [1:0] UCSZ_8 = 2'b11;

  // Parity mode encodings (bit 1 enables parity, bit 0 selects odd)
  localparam logic [1:0] UPM_NONE  = 2'b00;
  localparam logic [1:0] UPM_NONE1 = 2'b01;
  localparam logic [1:0] UPM_EVEN  = 2'b10;
  localparam logic [1:0] UPM_ODD   = 2'b11;

  // Samples per bit and last sample index for normal / double speed
  localparam int unsigned SAMPLES_X1 = 16;
  localparam int unsigned SAMPLES_X2 = 8;
  localparam logic [3:0]  LAST_X1    = 4'(SAMPLES_X1 - 1);
  localparam logic [3:0]  LAST_X2    = 4'(SAMPLES_X2 - 1);

  // Majority-vote sample positions; the bit is decided on the last one
  localparam logic [3:0] MAJ_LO_X1  = 4'd7;
  localparam logic [3:0] MAJ_MID_X1 = 4'd8;
  localparam logic [3:0] MAJ_HI_X1  = 4'd9;
  localparam logic [3:0] MAJ_LO_X2  = 4'd3;
  localparam logic [3:0] MAJ_MID_X2 = 4'd4;
  localparam logic [3:0] MAJ_HI_X2  = 4'd5;

  // Receive buffer payload: {data[7:0], frame error, parity error}
  localparam int unsigned FIFO_W = 10;

  function automatic logic [3:0] data_bits(input logic [1:0] ucsz);
    return 4'd5 + {2'b00, ucsz};
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/usart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : usart_rx_fifo
// Description : Two-entry receive buffer. A pop and a push in the same cycle
//               are handled as pop-then-push, so a full buffer still accepts
//               the new entry when the head is read at the same time.
// Revision    : 1.0 - initial release
// ============================================================================
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter int unsigned W = FIFO_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count;
  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         do_pop;
  logic         do_push;
  logic [1:0]   count_after_pop;

  assign empty           = (count == 2'd0);
  assign full            = (count == 2'd2);
  assign do_pop          = pop & ~empty;
  assign count_after_pop = count - {1'b0, do_pop};
  assign do_push         = push & (count_after_pop != 2'd2);
  assign rdata           = empty ? '0 : mem0;

  // Storage and occupancy; mem0 is always the head entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      mem0  <= '0;
      mem1  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (do_pop) mem0 <= mem1;
      if (do_push) begin
        if (count_after_pop == 2'd0) mem0 <= wdata;
        else                         mem1 <= wdata;
      end
      count <= count_after_pop + {1'b0, do_push};
    end
  end

endmodule
`default_nettype wire

// File: rtl/usart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : usart_receiver
// Description : USART receiver. Async mode oversamples each bit (16x or 8x)
//               with a 3-sample majority vote; sync mode samples one bit per
//               tick. Completed frames go into a 2-entry buffer with frame,
//               parity and overrun status.
// Revision    : 1.0 - initial release
// ============================================================================
module usart_receiver
  import usart_pkg::*;
#(
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxen,
  input  logic       i_sample_tick,
  input  logic       i_umsel,
  input  logic       i_u2x,
  input  logic [1:0] i_ucsz,
  input  logic [1:0] i_upm,
  input  logic       i_rxd,
  input  logic       i_udr_read,
  output logic [7:0] o_udr,
  output logic       o_rxc,
  output logic       o_fe,
  output logic       o_upe,
  output logic       o_dor,
  output logic       o_busy
);

  logic [SYNC_STAGES-1:0] rxd_sync;
  logic                   rxd_s;
  rx_state_t              state, state_n;
  logic [3:0]             cnt;
  logic [3:0]             bcnt;
  logic                   samp_lo, samp_mid;
  logic [7:0]             shreg;
  logic                   par_err;
  logic [3:0]             lo_idx, mid_idx, hi_idx, last_idx;
  logic                   decide, bit_end, bit_val, data_done, push;
  logic                   fifo_full, fifo_empty;
  logic [FIFO_W-1:0]      fifo_rdata;

  assign rxd_s = rxd_sync[SYNC_STAGES-1];

  // Line synchronizer, idles high
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rxd_sync <= '1;
    else       rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], i_rxd};
  end

  assign lo_idx   = i_u2x ? MAJ_LO_X2  : MAJ_LO_X1;
  assign mid_idx  = i_u2x ? MAJ_MID_X2 : MAJ_MID_X1;
  assign hi_idx   = i_u2x ? MAJ_HI_X2  : MAJ_HI_X1;
  assign last_idx = i_u2x ? LAST_X2    : LAST_X1;

  // In sync mode every tick is both the decision point and the end of a bit
  assign decide    = i_sample_tick & (i_umsel | (cnt == hi_idx));
  assign bit_end   = i_sample_tick & (i_umsel | (cnt == last_idx));
  assign bit_val   = i_umsel ? rxd_s : majority3(samp_lo, samp_mid, rxd_s);
  // Counts the bit being decided this cycle (sync mode decides and ends together)
  assign data_done = ((bcnt + {3'b000, decide}) == data_bits(i_ucsz));

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  // FSM next state and buffer push
  always_comb begin
    state_n = state;
    push    = 1'b0;
    if (!i_rxen) begin
      state_n = ST_IDLE;
    end else if (i_sample_tick) begin
      case (state)
        ST_IDLE:   if (!rxd_s) state_n = i_umsel ? ST_DATA : ST_START;
        ST_START: begin
          if (decide && bit_val) state_n = ST_IDLE;   // false start
          else if (bit_end)      state_n = ST_DATA;
        end
        ST_DATA:   if (bit_end && data_done) state_n = i_upm[1] ? ST_PARITY : ST_STOP;
        ST_PARITY: if (bit_end) state_n = ST_STOP;
        ST_STOP: begin
          if (decide) begin
            push    = 1'b1;
            state_n = ST_IDLE;
          end
        end
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  // Sample counter, majority history and frame assembly
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt      <= 4'd0;
      bcnt     <= 4'd0;
      samp_lo  <= 1'b1;
      samp_mid <= 1'b1;
      shreg    <= 8'd0;
      par_err  <= 1'b0;
    end else if (!i_rxen) begin
      cnt  <= 4'd0;
      bcnt <= 4'd0;
    end else if (i_sample_tick) begin
      // The start-detect tick is count 0, so the next tick is count 1
      if (state == ST_IDLE)       cnt <= rxd_s ? 4'd0 : 4'd1;
      else if (state_n == ST_IDLE) cnt <= 4'd0;
      else if (cnt == last_idx)    cnt <= 4'd0;
      else                         cnt <= cnt + 4'd1;

      if (cnt == lo_idx)  samp_lo  <= rxd_s;
      if (cnt == mid_idx) samp_mid <= rxd_s;

      if (state == ST_IDLE && !rxd_s) begin
        shreg   <= 8'd0;
        bcnt    <= 4'd0;
        par_err <= 1'b0;
      end
      if (state == ST_DATA && decide) begin
        shreg[bcnt[2:0]] <= bit_val;
        bcnt             <= bcnt + 4'd1;
      end
      // Unused upper data bits are zero, so the full-byte XOR is the data XOR
      if (state == ST_PARITY && decide) par_err <= bit_val ^ (^shreg) ^ i_upm[0];
    end
  end

  usart_rx_fifo #(.W(FIFO_W)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (~i_rxen),
    .push  (push),
    .pop   (i_udr_read),
    .wdata ({shreg, ~bit_val, par_err}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overrun: set on a dropped frame, cleared by the next accepted read
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                 o_dor <= 1'b0;
    else if (!i_rxen)                          o_dor <= 1'b0;
    else if (push && fifo_full && !i_udr_read) o_dor <= 1'b1;
    else if (i_udr_read && !fifo_empty)        o_dor <= 1'b0;
  end

  assign {o_udr, o_fe, o_upe} = fifo_rdata;
  assign o_rxc                = ~fifo_empty;
  assign o_busy               = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_usart_receiver
// Description : Self-checking bench for usart_receiver: a table of frames
//               with hand-written expectations, hand sequences for overrun,
//               glitch, disable and reset, then random frames checked against
//               a queue-based model of the receive buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usart_receiver;

  logic       clk = 1'b0;
  logic       rst, rxen, tick, umsel, u2x, rxd, udr_read;
  logic [1:0] ucsz, upm;
  logic [7:0] udr;
  logic       rxc, fe, upe, dor, busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  usart_receiver #(.SYNC_STAGES(2)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rxen        (rxen),
    .i_sample_tick (tick),
    .i_umsel       (umsel),
    .i_u2x         (u2x),
    .i_ucsz        (ucsz),
    .i_upm         (upm),
    .i_rxd         (rxd),
    .i_udr_read    (udr_read),
    .o_udr         (udr),
    .o_rxc         (rxc),
    .o_fe          (fe),
    .o_upe         (upe),
    .o_dor         (dor),
    .o_busy        (busy)
  );

  // Reference model: expected buffer contents and overrun flag
  typedef struct { logic [7:0] d; logic fe; logic upe; } ent_t;
  ent_t q[$];
  logic exp_dor;

  typedef struct {
    logic       umsel;
    logic       u2x;
    logic [1:0] ucsz;
    logic [1:0] upm;
    logic [7:0] data;
    logic       pflip;
    logic       stop;
    logic [7:0] exp_udr;
    logic       exp_fe;
    logic       exp_upe;
  } vec_t;
  vec_t vecs[9];

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // One sample tick whose synchronized line value is v
  task automatic sample(input logic v);
    rxd = v;
    repeat (3) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) sample(1'b1);
  endtask

  task automatic model_push(input logic [7:0] d, input logic f, input logic p);
    ent_t e;
    e.d = d; e.fe = f; e.upe = p;
    if (q.size() < 2) q.push_back(e);
    else              exp_dor = 1'b1;
  endtask

  // Drives one whole frame and records what the receiver should store
  task automatic send_frame(input logic m, input logic x2, input logic [1:0] cs,
                            input logic [1:0] pm, input logic [7:0] data,
                            input logic pflip, input logic stop);
    logic bits[12];
    int   nbit, nb, reps;
    logic [7:0] masked;
    logic par;
    umsel = m; u2x = x2; ucsz = cs; upm = pm;
    nb     = 5 + int'(cs);
    masked = data & 8'((1 << nb) - 1);
    par    = (^masked) ^ pm[0] ^ pflip;
    nbit = 0;
    bits[nbit++] = 1'b0;
    for (int i = 0; i < nb; i++) bits[nbit++] = data[i];
    if (pm[1]) bits[nbit++] = par;
    bits[nbit++] = stop;
    reps = m ? 1 : (x2 ? 8 : 16);
    for (int i = 0; i < nbit; i++) repeat (reps) sample(bits[i]);
    idle(m ? 2 : 16);
    model_push(masked, ~stop, pm[1] & pflip);
  endtask

  // Compares the head against the model, then pops it
  task automatic do_read();
    check1("rxc before read", rxc, q.size() > 0);
    check1("dor before read", dor, exp_dor);
    if (q.size() > 0) begin
      check8("udr", udr, q[0].d);
      check1("fe", fe, q[0].fe);
      check1("upe", upe, q[0].upe);
    end else begin
      check8("udr empty", udr, 8'h00);
    end
    udr_read = 1'b1;
    @(posedge clk);
    #1 udr_read = 1'b0;
    if (q.size() > 0) begin
      void'(q.pop_front());
      exp_dor = 1'b0;
    end
    check1("dor after read", dor, exp_dor);
    check1("rxc after read", rxc, q.size() > 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rxen = 1'b1; tick = 1'b0; umsel = 1'b0; u2x = 1'b0;
    ucsz = 2'b11; upm = 2'b00; rxd = 1'b1; udr_read = 1'b0; exp_dor = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 2'b11, 2'b00, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'b10, 2'b10, 8'h35, 1'b1, 1'b1, 8'h35, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 2'b11, 2'b00, 8'h0F, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'b11, 2'b00, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'hFF, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'b11, 2'b11, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 2'b01, 2'b10, 8'h2A, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 2'b01, 2'b11, 8'h15, 1'b1, 1'b1, 8'h15, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 2'b10, 2'b01, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("reset rxc", rxc, 1'b0);
    check8("reset udr", udr, 8'h00);
    check1("reset dor", dor, 1'b0);
    check1("reset busy", busy, 1'b0);
    rst = 1'b0;
    idle(4);

    // Table of single frames
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].umsel, vecs[i].u2x, vecs[i].ucsz, vecs[i].upm,
                 vecs[i].data, vecs[i].pflip, vecs[i].stop);
      check1("tbl rxc", rxc, 1'b1);
      check8("tbl udr", udr, vecs[i].exp_udr);
      check1("tbl fe", fe, vecs[i].exp_fe);
      check1("tbl upe", upe, vecs[i].exp_upe);
      check1("tbl busy", busy, 1'b0);
      do_read();
    end

    // Overrun: three frames, no reads
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h01, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h02, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h03, 1'b0, 1'b1);
    check1("ovr dor set", dor, 1'b1);
    check8("ovr head", udr, 8'h01);
    do_read();
    check1("ovr dor cleared", dor, 1'b0);
    check8("ovr second", udr, 8'h02);
    do_read();
    check1("ovr empty", rxc, 1'b0);
    do_read();   // read while empty is ignored

    // Glitch of 4 low samples on an idle line
    umsel = 1'b0; u2x = 1'b0;
    repeat (4) sample(1'b0);
    check1("glitch busy", busy, 1'b1);
    idle(12);
    check1("glitch idle", busy, 1'b0);
    check1("glitch no push", rxc, 1'b0);

    // Receiver disable flushes buffer and overrun
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h77, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h78, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h79, 1'b0, 1'b1);
    check1("dis pre dor", dor, 1'b1);
    rxen = 1'b0;
    @(posedge clk);
    #1;
    check1("dis rxc", rxc, 1'b0);
    check1("dis dor", dor, 1'b0);
    q.delete(); exp_dor = 1'b0;
    rxen = 1'b1;
    send_frame(1'b0, 1'b1, 2'b11, 2'b00, 8'hC3, 1'b0, 1'b1);
    do_read();

    // Reset in the middle of a frame with a non-empty buffer
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h11, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h22, 1'b0, 1'b1);
    send_frame(1'b0, 1'b0, 2'b11, 2'b00, 8'h33, 1'b0, 1'b1);
    repeat (16) sample(1'b0);
    repeat (16) sample(1'b1);
    repeat (16) sample(1'b0);
    check1("mid busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("rst busy", busy, 1'b0);
    check1("rst rxc", rxc, 1'b0);
    check8("rst udr", udr, 8'h00);
    check1("rst dor", dor, 1'b0);
    check1("rst fe", fe, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); exp_dor = 1'b0;
    idle(20);
    check1("post rst rxc", rxc, 1'b0);
    check1("post rst busy", busy, 1'b0);

    // Random frames against the model
    for (int n = 0; n < 30; n++) begin
      send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 8'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 1) == 1) do_read();
      if ($urandom_range(0, 3) == 0) do_read();
    end
    while (q.size() > 0) do_read();
    do_read();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
